// File: rtl/full_st0_tap_arb_pkg.sv
// full_st0_tap_arb_pkg: shared types and constants for the stage-0 tap memory arbiter.
package full_st0_tap_arb_pkg;
    localparam int TAP_ADDR_W     = 4;
    localparam int FLOAT_W        = 32;
    localparam int TAP_LANES      = 6;
    localparam int TAP_DATA_W     = TAP_LANES * FLOAT_W;
    localparam int STARVE_MAX_DEF = 8;

    typedef logic [FLOAT_W-1:0] float_24_8_t;
    typedef float_24_8_t [TAP_LANES-1:0] tap_word_t;

    typedef enum logic [2:0] {
        IDLE,
        UPD_RD,
        UPD_CAP,
        UPD_WAIT,
        UPD_WR
    } tap_arb_state_t;
endpackage

// File: rtl/full_st0_tap_arb_starve.sv
// full_st0_tap_arb_starve: saturating count of forward grants taken while an update waits.
module full_st0_tap_arb_starve
    import full_st0_tap_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt;

    assign at_max = cnt == CNT_W'(STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/full_st0_tap_arb.sv
// full_st0_tap_arb: arbitrates the stage-0 tap memory between forward reads and
// read-modify-write updates, owning all memory address and strobe generation.
module full_st0_tap_arb
    import full_st0_tap_arb_pkg::*;
#(
    parameter int ADDR_W     = TAP_ADDR_W,
    parameter int DATA_W     = TAP_DATA_W,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tap_enable,
    input  logic              fwd_req,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_gnt,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_data_vld,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    output logic              upd_gnt,
    output logic [DATA_W-1:0] upd_rd_data,
    output logic              upd_rd_vld,
    input  logic [DATA_W-1:0] upd_wr_data,
    input  logic              upd_wr_vld,
    output logic              upd_drop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);
    tap_arb_state_t    state_q, state_d;
    logic [ADDR_W-1:0] upd_addr_q;
    logic [DATA_W-1:0] wr_q;
    logic [DATA_W-1:0] fwd_hold_q;
    logic [DATA_W-1:0] upd_hold_q;
    logic              fwd_vld_q;
    logic              at_max;

    full_st0_tap_arb_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (upd_gnt || !upd_req),
        .inc   (fwd_gnt && upd_req),
        .at_max(at_max)
    );

    // Strobes are gated by reset so every output drops the moment reset rises.
    always_comb begin
        state_d    = state_q;
        fwd_gnt    = 1'b0;
        upd_gnt    = 1'b0;
        upd_rd_vld = 1'b0;
        upd_drop   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (fwd_req && !(upd_req && at_max)) begin
                        fwd_gnt   = 1'b1;
                        mem_rd_en = 1'b1;
                        mem_addr  = fwd_addr;
                    end else if (upd_req) begin
                        upd_gnt = 1'b1;
                        state_d = UPD_RD;
                    end
                end
                UPD_RD: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = upd_addr_q;
                    state_d   = UPD_CAP;
                end
                UPD_CAP: begin
                    upd_rd_vld = 1'b1;
                    state_d    = UPD_WAIT;
                end
                UPD_WAIT: state_d = upd_wr_vld ? UPD_WR : UPD_WAIT;
                UPD_WR: begin
                    mem_wr_en = tap_enable;
                    upd_drop  = !tap_enable;
                    mem_addr  = tap_enable ? upd_addr_q : '0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem_wr_data  = mem_wr_en ? wr_q : '0;
    assign fwd_data_vld = fwd_vld_q;
    assign fwd_data     = fwd_vld_q ? mem_rd_data : fwd_hold_q;
    assign upd_rd_data  = upd_rd_vld ? mem_rd_data : upd_hold_q;
    assign busy         = state_q != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            upd_addr_q <= '0;
            wr_q       <= '0;
            fwd_hold_q <= '0;
            upd_hold_q <= '0;
            fwd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fwd_vld_q <= fwd_gnt;
            if (fwd_vld_q)
                fwd_hold_q <= mem_rd_data;
            if (upd_rd_vld)
                upd_hold_q <= mem_rd_data;
            if (upd_gnt)
                upd_addr_q <= upd_addr;
            if (state_q == UPD_WAIT && upd_wr_vld)
                wr_q <= upd_wr_data;
        end
    end
endmodule

// File: tb/tb_full_st0_tap_arb.sv
// tb_full_st0_tap_arb: directed stimulus with a per-cycle reference model of the
// arbiter and a behavioural 1-cycle-latency tap memory.
module tb_full_st0_tap_arb;
    import full_st0_tap_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 192;
    localparam int SMAX = 8;

    logic          clk, reset, tap_enable;
    logic          fwd_req, fwd_gnt, fwd_data_vld;
    logic [AW-1:0] fwd_addr, upd_addr, mem_addr;
    logic [DW-1:0] fwd_data, upd_rd_data, upd_wr_data, mem_wr_data, mem_rd_data;
    logic          upd_req, upd_gnt, upd_rd_vld, upd_wr_vld, upd_drop;
    logic          mem_rd_en, mem_wr_en, busy;

    full_st0_tap_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .tap_enable(tap_enable),
        .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_gnt(fwd_gnt),
        .fwd_data(fwd_data), .fwd_data_vld(fwd_data_vld),
        .upd_req(upd_req), .upd_addr(upd_addr), .upd_gnt(upd_gnt),
        .upd_rd_data(upd_rd_data), .upd_rd_vld(upd_rd_vld),
        .upd_wr_data(upd_wr_data), .upd_wr_vld(upd_wr_vld), .upd_drop(upd_drop),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    function automatic tap_word_t init_word(input int n);
        logic [31:0] lane;
        lane = 32'(n) * 32'h0101_0101 + 32'h5a00_1234;
        return {6{lane}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        else
            n_pass++;
    endtask

    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_wr_en)
            ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en)
            mem_rd_data <= ram[mem_addr];
    end

    // Reference model: update phase 0 idle, 1 read, 2 capture, 3 wait, 4 write.
    logic [DW-1:0] ref_mem [16];
    int            m_ph, m_starve;
    logic          m_fpend;
    logic [AW-1:0] m_faddr, m_uaddr;
    logic [DW-1:0] m_fhold, m_uhold, m_wword;
    logic          e_fgnt, e_ugnt, e_wr;
    int            n_fgnt, n_fvld, n_busy, n_drop;

    always @(negedge clk) begin
        if (reset) begin
            m_ph = 0; m_starve = 0; m_fpend = 0; m_faddr = '0; m_uaddr = '0;
            m_fhold = '0; m_uhold = '0; m_wword = '0;
        end
        e_fgnt = !reset && m_ph == 0 && fwd_req && !(upd_req && m_starve == SMAX);
        e_ugnt = !reset && m_ph == 0 && upd_req && !e_fgnt;
        e_wr   = !reset && m_ph == 4 && tap_enable;
        chk("fwd_gnt", fwd_gnt, e_fgnt);
        chk("upd_gnt", upd_gnt, e_ugnt);
        chk("mem_rd_en", mem_rd_en, e_fgnt || (!reset && m_ph == 1));
        chk("mem_wr_en", mem_wr_en, e_wr);
        chk("mem_addr", mem_addr, e_fgnt ? fwd_addr : (!reset && (m_ph == 1 || e_wr)) ? m_uaddr : '0);
        chk("mem_wr_data", mem_wr_data, e_wr ? m_wword : '0);
        chk("upd_drop", upd_drop, !reset && m_ph == 4 && !tap_enable);
        chk("upd_rd_vld", upd_rd_vld, !reset && m_ph == 2);
        chk("upd_rd_data", upd_rd_data, (!reset && m_ph == 2) ? ref_mem[m_uaddr] : m_uhold);
        chk("fwd_data_vld", fwd_data_vld, m_fpend);
        chk("fwd_data", fwd_data, m_fpend ? ref_mem[m_faddr] : m_fhold);
        chk("busy", busy, m_ph != 0);
        if (fwd_gnt) n_fgnt++;
        if (fwd_data_vld) n_fvld++;
        if (busy) n_busy++;
        if (upd_drop) n_drop++;
        if (!reset) begin
            if (m_fpend) m_fhold = ref_mem[m_faddr];
            if (m_ph == 2) m_uhold = ref_mem[m_uaddr];
            if (e_wr) ref_mem[m_uaddr] = m_wword;
            m_fpend = e_fgnt;
            if (e_fgnt) m_faddr = fwd_addr;
            if (e_ugnt || !upd_req) m_starve = 0;
            else if (e_fgnt && m_starve < SMAX) m_starve++;
            case (m_ph)
                0: if (e_ugnt) begin m_uaddr = upd_addr; m_ph = 1; end
                1: m_ph = 2;
                2: m_ph = 3;
                3: if (upd_wr_vld) begin m_wword = upd_wr_data; m_ph = 4; end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the grant cycle; walks the update through to the first idle cycle.
    task automatic upd_tail(input logic [DW-1:0] d, input int w, input bit early, input logic [DW-1:0] exp_rd);
        step();
        upd_req = 1'b0;
        step();
        if (early) begin
            upd_wr_vld = 1'b1;
            upd_wr_data = ~d;
        end
        @(negedge clk);
        chk("cap_rd_data", upd_rd_data, exp_rd);
        step();
        upd_wr_vld = 1'b0;
        repeat (w) step();
        upd_wr_vld = 1'b1;
        upd_wr_data = d;
        step();
        upd_wr_vld = 1'b0;
        @(negedge clk);
        chk("wr_strobe", mem_wr_en, tap_enable);
        step();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        fwd_req = 1'b1;
        fwd_addr = a;
        step();
        fwd_req = 1'b0;
        @(negedge clk);
        chk("readback_vld", fwd_data_vld, 1'b1);
        chk("readback", fwd_data, exp);
        step();
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 16; i++) begin
            ram[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem_rd_data = '0;
        reset = 1'b1; tap_enable = 1'b1; fwd_req = 1'b0; fwd_addr = '0;
        upd_req = 1'b0; upd_addr = '0; upd_wr_vld = 1'b0; upd_wr_data = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fwd_data", fwd_data, '0);
        step();
        reset = 1'b0;
        step();

        // Forward stream over all addresses.
        n_fgnt = 0; n_fvld = 0;
        for (int a = 0; a < 16; a++) begin
            fwd_req = 1'b1;
            fwd_addr = AW'(a);
            step();
        end
        fwd_req = 1'b0;
        step();
        step();
        chk("stream_gnts", 32'(n_fgnt), 32'd16);
        chk("stream_vlds", 32'(n_fvld), 32'd16);

        // Single update of address 5.
        n_busy = 0;
        upd_req = 1'b1;
        upd_addr = 4'd5;
        @(negedge clk);
        chk("single_gnt", upd_gnt, 1'b1);
        upd_tail(init_word(5) + 1, 2, 0, init_word(5));
        chk("single_busy", 32'(n_busy), 32'd6);
        rd(4'd5, init_word(5) + 1);

        // Starvation bound with forward held high.
        n_fgnt = 0;
        got = 0;
        fwd_req = 1'b1;
        fwd_addr = '0;
        upd_req = 1'b1;
        upd_addr = 4'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_gnt) begin
                got = 1;
                break;
            end
            step();
            fwd_addr = fwd_addr + 1'b1;
        end
        chk("starve_upd_gnt", got, 1'b1);
        chk("starve_fwd_gnts", 32'(n_fgnt), 32'd8);
        n_busy = 0;
        upd_tail(~init_word(7), 0, 0, init_word(7));
        chk("min_busy", 32'(n_busy), 32'd4);
        @(negedge clk);
        chk("fwd_resume", fwd_gnt, 1'b1);
        fwd_req = 1'b0;
        step();

        // Simultaneous requests: forward first, update when forward drops.
        fwd_req = 1'b1;
        fwd_addr = 4'd1;
        upd_req = 1'b1;
        upd_addr = 4'd2;
        @(negedge clk);
        chk("sim_fwd_first", fwd_gnt, 1'b1);
        chk("sim_upd_held", upd_gnt, 1'b0);
        step();
        step();
        fwd_req = 1'b0;
        @(negedge clk);
        chk("sim_upd_gnt", upd_gnt, 1'b1);
        upd_tail(~init_word(2), 1, 1, init_word(2));
        rd(4'd2, ~init_word(2));
        rd(4'd7, ~init_word(7));

        // Update write suppressed by tap_enable.
        n_drop = 0;
        tap_enable = 1'b0;
        upd_req = 1'b1;
        upd_addr = 4'd9;
        @(negedge clk);
        upd_tail(192'h1234, 1, 0, init_word(9));
        tap_enable = 1'b1;
        chk("drop_cnt", 32'(n_drop), 32'd1);
        rd(4'd9, init_word(9));

        // Asynchronous reset while waiting for write data.
        upd_req = 1'b1;
        upd_addr = 4'd3;
        @(negedge clk);
        step();
        upd_req = 1'b0;
        step();
        step();
        fwd_req = 1'b1;
        fwd_addr = 4'd3;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_fwd_gnt", fwd_gnt, 1'b0);
        chk("arst_mem_rd_en", mem_rd_en, 1'b0);
        chk("arst_mem_addr", mem_addr, '0);
        chk("arst_upd_rd_data", upd_rd_data, '0);
        upd_wr_vld = 1'b1;
        upd_wr_data = '1;
        step();
        step();
        reset = 1'b0;
        upd_wr_vld = 1'b0;
        fwd_req = 1'b0;
        step();
        chk("arst_no_write", ram[3], init_word(3));
        rd(4'd3, init_word(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
